// File: rtl/delay_buf_sa.sv
// Per-channel programmable delay stage for the delay-and-sum beamformer.
// Each channel keeps a circular sample history; the time-aligned vector is emitted with sum_en.
module delay_buf_sa #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned MAX_DELAY    = 16,
  parameter int unsigned DELAY_WIDTH  = $clog2(MAX_DELAY)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic                                 stop,
  input  logic [NUM_CHANNELS*DELAY_WIDTH-1:0]  delay_values,
  input  logic                                 sample_valid,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]   sample_in,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0]   delayed_sample,
  output logic                                 sum_en,
  output logic                                 start_sum,
  output logic                                 busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  logic [1:0]                            state, state_nxt;
  logic [NUM_CHANNELS*DELAY_WIDTH-1:0]   d_lat;
  logic [DELAY_WIDTH-1:0]                dmax, dmax_new;
  logic [DELAY_WIDTH-1:0]                wr_ptr;
  logic [DELAY_WIDTH-1:0]                fill_cnt;
  logic                                  first_pending;
  logic                                  accept, fire;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0]    rd_data;

  // Largest requested delay sets how many samples must be buffered before output.
  always_comb begin
    dmax_new = '0;
    for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
      if (delay_values[i*DELAY_WIDTH +: DELAY_WIDTH] > dmax_new)
        dmax_new = delay_values[i*DELAY_WIDTH +: DELAY_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state plus accept/fire strobes; start always overrides stop and the sample.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    fire      = 1'b0;
    if (sample_valid && !start && (state == S_FILL || state == S_RUN)) begin
      accept = 1'b1;
      if (state == S_RUN || fill_cnt == dmax) fire = 1'b1;
    end
    if (start)
      state_nxt = (dmax_new != '0) ? S_FILL : S_RUN;
    else if (state != S_FILL && state != S_RUN)
      state_nxt = S_IDLE;
    else if (stop)
      state_nxt = S_IDLE;
    else if (state == S_FILL && fire)
      state_nxt = S_RUN;
  end

  for (genvar c = 0; c < int'(NUM_CHANNELS); c++) begin : g_ch
    logic [DATA_WIDTH-1:0]  mem [MAX_DELAY];
    logic [DELAY_WIDTH-1:0] d_ch;

    assign d_ch = d_lat[c*DELAY_WIDTH +: DELAY_WIDTH];

    always_ff @(posedge clk) begin
      if (accept) mem[wr_ptr] <= sample_in[c*DATA_WIDTH +: DATA_WIDTH];
    end

    // Read happens before this cycle's write; zero delay bypasses the buffer.
    assign rd_data[c*DATA_WIDTH +: DATA_WIDTH] =
      (d_ch == '0) ? sample_in[c*DATA_WIDTH +: DATA_WIDTH]
                   : mem[DELAY_WIDTH'(wr_ptr - d_ch)];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_lat          <= '0;
      dmax           <= '0;
      wr_ptr         <= '0;
      fill_cnt       <= '0;
      first_pending  <= 1'b0;
      delayed_sample <= '0;
      sum_en         <= 1'b0;
      start_sum      <= 1'b0;
      busy           <= 1'b0;
    end else begin
      busy      <= (state_nxt != S_IDLE);
      sum_en    <= fire;
      start_sum <= fire && first_pending;
      if (fire) begin
        delayed_sample <= rd_data;
        first_pending  <= 1'b0;
      end
      if (start) begin
        d_lat         <= delay_values;
        dmax          <= dmax_new;
        wr_ptr        <= '0;
        fill_cnt      <= '0;
        first_pending <= 1'b1;
      end else if (accept) begin
        wr_ptr <= wr_ptr + DELAY_WIDTH'(1);
        if (state == S_FILL) fill_cnt <= fill_cnt + DELAY_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_delay_buf_sa.sv
// Directed bench for delay_buf_sa: alignment, zero delay, wrap, gaps/stop, restart and reset.
module tb_delay_buf_sa;

  localparam int unsigned DW = 16;
  localparam int unsigned NC = 4;
  localparam int unsigned MD = 16;
  localparam int unsigned KW = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic                start, stop, sample_valid;
  logic [NC*KW-1:0]    delay_values;
  logic [NC*DW-1:0]    sample_in;
  logic [NC*DW-1:0]    delayed_sample;
  logic                sum_en, start_sum, busy;

  int total = 0;
  int bad   = 0;

  delay_buf_sa #(.DATA_WIDTH(DW), .NUM_CHANNELS(NC), .MAX_DELAY(MD)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .delay_values(delay_values), .sample_valid(sample_valid), .sample_in(sample_in),
    .delayed_sample(delayed_sample), .sum_en(sum_en), .start_sum(start_sum), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [NC*DW-1:0] pack(input int a, input int b, input int c, input int d);
    return {DW'(d), DW'(c), DW'(b), DW'(a)};
  endfunction

  // Apply inputs for one cycle, then observe 1 time unit after the edge.
  task automatic tick(input logic st, input logic sp, input logic sv, input logic [NC*DW-1:0] smp);
    start = st; stop = sp; sample_valid = sv; sample_in = smp;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0; sample_valid = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if (delayed_sample !== '0 || sum_en !== 1'b0 || start_sum !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: ds=%h sum_en=%b start_sum=%b busy=%b required all 0",
               delayed_sample, sum_en, start_sum, busy);
    end
  endtask

  task automatic test_basic();
    int outs = 0;
    logic [NC*DW-1:0] exp;
    delay_values = {4'd3, 4'd2, 4'd1, 4'd0};
    tick(1, 0, 0, '0);
    for (int k = 0; k < 8; k++) begin
      tick(0, 0, 1, pack(k, 100 + k, 200 + k, 300 + k));
      if (sum_en) outs++;
      total++;
      if (k < 3) begin
        if (sum_en !== 1'b0) begin
          bad++; $display("FAIL basic_fill k=%0d: sum_en=%b required 0", k, sum_en);
        end
      end else begin
        exp = pack(k, 100 + k - 1, 200 + k - 2, 300 + k - 3);
        if (sum_en !== 1'b1 || delayed_sample !== exp || start_sum !== (k == 3)) begin
          bad++;
          $display("FAIL basic_out k=%0d: sum_en=%b ss=%b ds=%h required 1 %b %h",
                   k, sum_en, start_sum, delayed_sample, (k == 3), exp);
        end
      end
    end
    tick(0, 0, 0, '0);
    total++;
    if (sum_en !== 1'b0 || delayed_sample !== pack(7, 106, 205, 304) || busy !== 1'b1) begin
      bad++;
      $display("FAIL basic_hold: sum_en=%b ds=%h busy=%b required 0 %h 1",
               sum_en, delayed_sample, busy, pack(7, 106, 205, 304));
    end
    tick(0, 1, 0, '0);
    total++;
    if (outs != 5 || busy !== 1'b0) begin
      bad++; $display("FAIL basic_count: outs=%0d busy=%b required 5 0", outs, busy);
    end
  endtask

  task automatic test_zero();
    delay_values = '0;
    tick(1, 0, 0, '0);
    tick(0, 0, 1, pack(7, 8, 9, 10));
    total++;
    if (sum_en !== 1'b1 || start_sum !== 1'b1 || delayed_sample !== pack(7, 8, 9, 10)) begin
      bad++;
      $display("FAIL zero_out: sum_en=%b ss=%b ds=%h required 1 1 %h",
               sum_en, start_sum, delayed_sample, pack(7, 8, 9, 10));
    end
    tick(0, 0, 0, '0);
    total++;
    if (busy !== 1'b1 || sum_en !== 1'b0) begin
      bad++; $display("FAIL zero_busy: busy=%b sum_en=%b required 1 0", busy, sum_en);
    end
    tick(0, 1, 0, '0);
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL zero_stop: busy=%b required 0", busy);
    end
  endtask

  task automatic test_wrap();
    int outs = 0;
    int errs = 0;
    delay_values = {4'd0, 4'd0, 4'd0, 4'd15};
    tick(1, 0, 0, '0);
    for (int k = 0; k < 40; k++) begin
      tick(0, 0, 1, pack(k, 500 + k, 0, 0));
      if (sum_en) outs++;
      if (k < 15) begin
        if (sum_en !== 1'b0) errs++;
      end else if (sum_en !== 1'b1 || delayed_sample !== pack(k - 15, 500 + k, 0, 0)) begin
        errs++;
        $display("FAIL wrap_k%0d: ds=%h required %h", k, delayed_sample, pack(k - 15, 500 + k, 0, 0));
      end
    end
    total++;
    if (errs != 0 || outs != 25) begin
      bad++; $display("FAIL wrap_total: errs=%0d outs=%0d required 0 25", errs, outs);
    end
    tick(0, 1, 0, '0);
  endtask

  task automatic test_gap_stop();
    delay_values = {4'd0, 4'd0, 4'd0, 4'd2};
    tick(1, 0, 0, '0);
    for (int k = 0; k < 6; k++) begin
      tick(0, (k == 5), 1, pack(k, 10 + k, 20 + k, 30 + k));
      total++;
      if (k < 2) begin
        if (sum_en !== 1'b0) begin
          bad++; $display("FAIL gap_fill k=%0d: sum_en=%b required 0", k, sum_en);
        end
      end else if (sum_en !== 1'b1 || delayed_sample !== pack(k - 2, 10 + k, 20 + k, 30 + k)) begin
        bad++;
        $display("FAIL gap_out k=%0d: sum_en=%b ds=%h required 1 %h",
                 k, sum_en, delayed_sample, pack(k - 2, 10 + k, 20 + k, 30 + k));
      end
      if (k < 5) begin
        for (int g = 0; g < 2; g++) begin
          tick(0, 0, 0, '0);
          total++;
          if (sum_en !== 1'b0) begin
            bad++; $display("FAIL gap_idle k=%0d: sum_en=%b required 0", k, sum_en);
          end
        end
      end
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL gap_busy: busy=%b required 0", busy);
    end
    for (int k = 0; k < 3; k++) begin
      tick(0, 0, 1, pack(99, 99, 99, 99));
      total++;
      if (sum_en !== 1'b0 || delayed_sample !== pack(3, 15, 25, 35)) begin
        bad++; $display("FAIL gap_after: sum_en=%b ds=%h required 0 %h", sum_en, delayed_sample, pack(3, 15, 25, 35));
      end
    end
  endtask

  task automatic test_restart();
    delay_values = '0;
    tick(1, 0, 0, '0);
    tick(0, 0, 1, pack(1, 2, 3, 4));
    tick(0, 0, 1, pack(5, 6, 7, 8));
    delay_values = {4'd1, 4'd1, 4'd1, 4'd1};
    tick(1, 1, 1, pack(66, 66, 66, 66));
    total++;
    if (sum_en !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL restart_cycle: sum_en=%b busy=%b required 0 1", sum_en, busy);
    end
    tick(0, 0, 1, pack(40, 41, 42, 43));
    total++;
    if (sum_en !== 1'b0) begin
      bad++; $display("FAIL restart_fill: sum_en=%b required 0", sum_en);
    end
    tick(0, 0, 1, pack(50, 51, 52, 53));
    total++;
    if (sum_en !== 1'b1 || start_sum !== 1'b1 || delayed_sample !== pack(40, 41, 42, 43)) begin
      bad++;
      $display("FAIL restart_first: sum_en=%b ss=%b ds=%h required 1 1 %h",
               sum_en, start_sum, delayed_sample, pack(40, 41, 42, 43));
    end
    tick(0, 1, 0, '0);
  endtask

  task automatic test_reset_mid();
    delay_values = {4'd0, 4'd0, 4'd0, 4'd1};
    tick(1, 0, 0, '0);
    for (int k = 0; k < 3; k++) tick(0, 0, 1, pack(k + 1, 9, 9, 9));
    sample_valid = 1'b1;
    sample_in = pack(77, 77, 77, 77);
    #1 reset = 1'b1;
    #1;
    total++;
    if (delayed_sample !== '0 || sum_en !== 1'b0 || start_sum !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: ds=%h sum_en=%b ss=%b busy=%b required all 0",
               delayed_sample, sum_en, start_sum, busy);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    tick(0, 0, 1, pack(77, 77, 77, 77));
    total++;
    if (sum_en !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_idle: sum_en=%b busy=%b required 0 0", sum_en, busy);
    end
    tick(1, 0, 0, '0);
    tick(0, 0, 1, pack(11, 12, 13, 14));
    total++;
    if (sum_en !== 1'b0) begin
      bad++; $display("FAIL reset_refill: sum_en=%b required 0", sum_en);
    end
    tick(0, 0, 1, pack(21, 22, 23, 24));
    total++;
    if (sum_en !== 1'b1 || start_sum !== 1'b1 || delayed_sample !== pack(11, 22, 23, 24)) begin
      bad++;
      $display("FAIL reset_resume: sum_en=%b ss=%b ds=%h required 1 1 %h",
               sum_en, start_sum, delayed_sample, pack(11, 22, 23, 24));
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; sample_valid = 1'b0;
    delay_values = '0; sample_in = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b0;
    tick(0, 0, 0, '0);
    test_basic();
    test_zero();
    test_wrap();
    test_gap_stop();
    test_restart();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
